// File: rtl/nios_system_led_pkg.sv
// Shared constants for the LED output PIO: register word addresses and default widths.
package nios_system_led_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_PERIOD_WIDTH = 24;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
  localparam logic [2:0] ADDR_PERIOD     = 3'd2;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

endpackage

// File: rtl/nios_system_led_blink_timer.sv
// Half-period counter and phase toggle; restart or a zero period pins phase high.
module nios_system_led_blink_timer #(
  parameter int PERIOD_WIDTH = nios_system_led_pkg::DEF_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    restart,
  output logic                    phase
);

  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic                    r_phase;
  logic                    w_tc;

  // Terminal count is period-1, so an all-ones period still hits it before the counter wraps.
  assign w_tc  = (r_cnt == (period - PERIOD_WIDTH'(1)));
  assign phase = r_phase;

  always_ff @(posedge clk) begin
    if (reset || restart || (period == '0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_tc) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/nios_system_led_pio.sv
// Avalon-MM LED output PIO: data register with set/clear aliases and per-bit hardware blink.
module nios_system_led_pio
  import nios_system_led_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int                    PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_mask;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [31:0]             r_readdata;
  logic [DATA_WIDTH-1:0]   r_out;

  logic                    w_wr;
  logic                    w_restart;
  logic                    w_phase;
  logic [DATA_WIDTH-1:0]   w_wd;
  logic [31:0]             w_rd_mux;

  assign w_wr      = chipselect && !write_n;
  assign w_wd      = writedata[DATA_WIDTH-1:0];
  assign w_restart = w_wr && ((address == ADDR_PERIOD) || (address == ADDR_STATUS));

  nios_system_led_blink_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .period  (r_period),
    .restart (w_restart),
    .phase   (w_phase)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      r_period <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:       r_data   <= w_wd;
        ADDR_BLINK_MASK: r_mask   <= w_wd;
        ADDR_PERIOD:     r_period <= writedata[PERIOD_WIDTH-1:0];
        ADDR_OUTSET:     r_data   <= r_data | w_wd;
        ADDR_OUTCLEAR:   r_data   <= r_data & ~w_wd;
        default:         ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:       w_rd_mux[DATA_WIDTH-1:0]   = r_data;
      ADDR_BLINK_MASK: w_rd_mux[DATA_WIDTH-1:0]   = r_mask;
      ADDR_PERIOD:     w_rd_mux[PERIOD_WIDTH-1:0] = r_period;
      ADDR_STATUS:     w_rd_mux[0]                = w_phase;
      default:         w_rd_mux = '0;
    endcase
  end

  // Output is gated from the registered state, so it trails DATA/MASK/phase by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
      r_out      <= '0;
    end else begin
      r_readdata <= w_rd_mux;
      r_out      <= r_data & (~r_mask | {DATA_WIDTH{w_phase}});
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out;

endmodule

// File: tb/tb_nios_system_led_pio.sv
// Directed self-checking bench for the LED PIO, with a second instance using a nonzero reset value.
module tb_nios_system_led_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata2;
  logic [7:0]  out_port, out_port2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_system_led_pio #(.DATA_WIDTH(8), .PERIOD_WIDTH(24), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  nios_system_led_pio #(.DATA_WIDTH(8), .PERIOD_WIDTH(24), .RESET_VALUE(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2), .out_port(out_port2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Write presented for one cycle; returns at the negedge after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  logic [31:0] v;
  logic [7:0]  exp_out;
  logic        exp_ph;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out", {24'h0, out_port}, 32'h0);
    chk("rst_out2", {24'h0, out_port2}, 32'hA5);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk($sformatf("rst_rd%0d", a), v, (a == 3) ? 32'h1 : 32'h0);
    end
    rd(3'd0, v);
    chk("rst_rd2_data", readdata2, 32'hA5);

    // DATA write, OUTSET, OUTCLEAR; upper writedata bits dropped
    wr(3'd0, 32'hABCD_003C);
    rd(3'd0, v); chk("data_wr", v, 32'h3C);
    chk("data_out", {24'h0, out_port}, 32'h3C);
    wr(3'd4, 32'hFFFF_FF81);
    @(negedge clk); chk("outset_out", {24'h0, out_port}, 32'hBD);
    rd(3'd0, v); chk("outset_rd", v, 32'hBD);
    wr(3'd5, 32'h0000_000C);
    @(negedge clk); chk("outclr_out", {24'h0, out_port}, 32'hB1);
    rd(3'd0, v); chk("outclr_rd", v, 32'hB1);
    rd(3'd4, v); chk("rd_outset_zero", v, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0, v); chk("rsvd_wr_ignored", v, 32'hB1);

    // Blink: PERIOD=4, 4 cycles per phase
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h0F);
    wr(3'd2, 32'd4);       // returns at negedge after E0
    address = 3'd3;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_ph  = (((k - 1) / 4) % 2) == 0;
      exp_out = exp_ph ? 8'hFF : 8'hF0;
      chk($sformatf("blink_out_k%0d", k), {24'h0, out_port}, {24'h0, exp_out});
      chk($sformatf("blink_st_k%0d", k), readdata, {31'h0, exp_ph});
    end
    // PERIOD=3 written on the edge where the old count would toggle phase
    address = 3'd2; writedata = 32'd3; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 3'd3;
    chk("restart_out_k12", {24'h0, out_port}, 32'hFF);
    for (int k = 13; k <= 21; k++) begin
      @(negedge clk);
      exp_ph  = (((k - 13) / 3) % 2) == 0;
      exp_out = exp_ph ? 8'hFF : 8'hF0;
      chk($sformatf("restart_out_k%0d", k), {24'h0, out_port}, {24'h0, exp_out});
      if (k >= 14)
        chk($sformatf("restart_st_k%0d", k), readdata, {31'h0, exp_ph});
    end

    // STATUS write restarts: phase forced high
    wr(3'd3, 32'h0);
    address = 3'd3;
    @(negedge clk); chk("status_wr_phase", readdata, 32'h1);

    // PERIOD=0: blink bits steady on
    wr(3'd2, 32'd0);
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'h55);
    @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      chk("p0_steady", {24'h0, out_port}, 32'h55);
    end

    // Reset mid-blink with a coincident DATA write
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h0F);
    wr(3'd2, 32'd4);
    repeat (5) @(negedge clk);
    chk("pre_rst_out", {24'h0, out_port}, 32'hF0);
    reset = 1'b1; address = 3'd0; writedata = 32'h12; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    chk("mid_rst_out", {24'h0, out_port}, 32'h0);
    chk("mid_rst_rd", readdata, 32'h0);
    @(negedge clk);
    chk("mid_rst_out2", {24'h0, out_port2}, 32'hA5);
    rd(3'd0, v); chk("mid_rst_data", v, 32'h0);
    chk("mid_rst_data2", readdata2, 32'hA5);
    rd(3'd1, v); chk("mid_rst_mask", v, 32'h0);
    rd(3'd2, v); chk("mid_rst_period", v, 32'h0);
    rd(3'd3, v); chk("mid_rst_status", v, 32'h1);
    chk("mid_rst_out_hold", {24'h0, out_port}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
